fetch_decode_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage. It accepts one fetched instruction word plus its PC per cycle and holds up to DEPTH entries in order. It presents the oldest entry to decode with a valid/stall handshake and back-pressures fetch through its stall input. A flush empties the queue when the pipeline redirects, for example on a taken branch.

---
 rtl/fetch_decode_queue.sv | 124 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// In-order {insn, pc} queue between fetch and decode with valid/stall handshake and flush.
// Optional zero-latency empty-queue bypass is enabled by defining FDQ_BYPASS_EN.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:31]      in_insn,
    input  logic [0:31]      in_pc,
    input  logic             in_valid,
    output logic             in_stall,
    output logic [0:31]      out_insn,
    output logic [0:31]      out_pc,
    output logic             out_valid,
    input  logic             out_stall,
    input  logic             flush,
    output logic [0:PTR_W]   count
);

    localparam logic [0:PTR_W] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [0:PTR_W] ZERO_COUNT = '0;

    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_next;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        wr_ptr_next;
    logic [0:PTR_W]          count_reg;
    logic [0:PTR_W]          count_next;
    logic [0:DEPTH-1][0:31]  insn_mem;
    logic [0:DEPTH-1][0:31]  pc_mem;
    logic                    stored_valid;
    logic                    bypass_active;
    logic                    bypass_take;
    logic                    push;
    logic                    pop;

    assign stored_valid = (count_reg != ZERO_COUNT);
    // Full is decoded from registered occupancy only, so decode stall never reaches fetch stall.
    assign in_stall     = (count_reg == FULL_COUNT);
    assign count        = count_reg;

`ifdef FDQ_BYPASS_EN
    assign bypass_active = !stored_valid && in_valid && !flush;
`else
    assign bypass_active = 1'b0;
`endif

    // A bypassed word that decode accepts this cycle is never written into the buffer.
    assign bypass_take = bypass_active && !out_stall;
    assign push        = in_valid && !in_stall && !flush && !bypass_take;
    assign pop         = stored_valid && !out_stall && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [0:31] insn_reg;
            logic [0:31] pc_reg;
            logic        write_en;

            assign write_en = push && (wr_ptr_reg == PTR_W'(gi));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    insn_reg <= '0;
                    pc_reg   <= '0;
                end else if (write_en) begin
                    insn_reg <= in_insn;
                    pc_reg   <= in_pc;
                end
            end

            assign insn_mem[gi] = insn_reg;
            assign pc_mem[gi]   = pc_reg;
        end
    endgenerate

    always_comb begin
        out_valid = stored_valid;
        out_insn  = insn_mem[rd_ptr_reg];
        out_pc    = pc_mem[rd_ptr_reg];
        if (bypass_active) begin
            out_valid = 1'b1;
            out_insn  = in_insn;
            out_pc    = in_pc;
        end
    end

    // Flush wins over push and pop; stored words are left in place and simply become unreachable.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
                2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [0:31]       in_insn;
    logic [0:31]       in_pc;
    logic              in_valid;
    logic              in_stall;
    logic [0:31]       out_insn;
    logic [0:31]       out_pc;
    logic              out_valid;
    logic              out_stall;
    logic              flush;
    logic [0:PTR_W]    count;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } entry_t;

    entry_t model_q[$];
    int     checks = 0;
    int     failures = 0;
    int     max_count;
    bit     stall_seen;

    fetch_decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_insn   (in_insn),
        .in_pc     (in_pc),
        .in_valid  (in_valid),
        .in_stall  (in_stall),
        .out_insn  (out_insn),
        .out_pc    (out_pc),
        .out_valid (out_valid),
        .out_stall (out_stall),
        .flush     (flush),
        .count     (count)
    );

    always #5 clock = ~clock;

    // One cycle: drive inputs just after a falling edge, compare against the model,
    // then let the rising edge commit and advance the model by the queue rules.
    task automatic step(input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                        input logic os, input logic fl);
        int     size;
        bit     exp_full;
        bit     exp_valid;
        bit     bypass;
        bit     do_pop;
        bit     do_push;
        entry_t head;
        entry_t seen;
        in_valid  = iv;
        in_insn   = insn;
        in_pc     = pc;
        out_stall = os;
        flush     = fl;
        #1;
        size     = model_q.size();
        exp_full = (size == DEPTH);
`ifdef FDQ_BYPASS_EN
        bypass   = (size == 0) && iv && !fl;
`else
        bypass   = 1'b0;
`endif
        exp_valid = (size != 0) || bypass;
        head = '0;
        if (bypass) head = '{insn: insn, pc: pc};
        else if (size != 0) head = model_q[0];
        seen = '{insn: out_insn, pc: out_pc};

        checks++;
        if (int'(count) !== size) begin
            failures++;
            $display("FAIL count: got %0d expected %0d", count, size);
        end
        checks++;
        if (in_stall !== exp_full) begin
            failures++;
            $display("FAIL in_stall: got %b expected %b", in_stall, exp_full);
        end
        checks++;
        if (out_valid !== exp_valid) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (seen !== head) begin
                failures++;
                $display("FAIL head: got insn=%08h pc=%08h expected insn=%08h pc=%08h",
                         out_insn, out_pc, head.insn, head.pc);
            end
        end
        if (int'(count) > max_count) max_count = int'(count);
        if (in_stall === 1'b1) stall_seen = 1'b1;

        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else begin
            do_pop  = exp_valid && !os;
            do_push = iv && !exp_full && !(bypass && do_pop);
            if (do_pop) begin
                $display("pop  insn=%08h pc=%08h", head.insn, head.pc);
                if (!bypass) void'(model_q.pop_front());
            end
            if (do_push) model_q.push_back('{insn: insn, pc: pc});
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic os);
        step(1'b0, 32'h0, 32'h0, os, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_stall = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (count !== '0 || in_stall !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got count=%0d in_stall=%b out_valid=%b expected 0 0 0",
                     count, in_stall, out_valid);
        end
        checks++;
        if (out_insn !== 32'h0 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got insn=%08h pc=%08h expected 0 0", out_insn, out_pc);
        end
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h24020001 + 32'(i), 32'h80020000 + 32'(4 * i), 1'b1, 1'b0);
        // Fifth push while full must be dropped; the step sees count=4 and in_stall=1.
        step(1'b1, 32'h24020005, 32'h80020010, 1'b1, 1'b0);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) idle(1'b0);
        idle(1'b0);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h10000000 + 32'($urandom_range(0, 32'hFFFF)), 32'h80030000 + 32'(4 * i),
                 1'b0, 1'b0);
            checks++;
            if (int'(count) > 1) begin
                failures++;
                $display("FAIL stream_count: got %0d expected <= 1", count);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 32'h80040000 + 32'(4 * i), 1'b1, 1'b0);
        step(1'b1, 32'hDEADBEEF, 32'h8004000C, 1'b0, 1'b1);
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush: got count=%0d out_valid=%b in_stall=%b expected 0 0 0",
                     count, out_valid, in_stall);
        end
        step(1'b1, 32'h24020099, 32'h80050000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++)
            step(1'b1, $urandom, 32'h80060000 + 32'(4 * i), 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got count=%0d out_valid=%b in_stall=%b expected 0 0 0",
                     count, out_valid, in_stall);
        end
        @(negedge clock);
        reset = 1'b0;
        model_q.delete();
        step(1'b1, 32'h24020077, 32'h80070000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_alternate();
        max_count  = 0;
        stall_seen = 1'b0;
        for (int i = 0; i < 16; i++)
            step(1'b1, $urandom, 32'h80080000 + 32'(4 * i), (i % 2) == 0, 1'b0);
        checks++;
        if (max_count != DEPTH || !stall_seen) begin
            failures++;
            $display("FAIL alternate: got max_count=%0d stall_seen=%b expected %0d 1",
                     max_count, stall_seen, DEPTH);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        drain();
    endtask

    initial begin
        max_count  = 0;
        stall_seen = 1'b0;
        @(negedge clock);
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_async_reset();
        test_alternate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
